// File: rtl/router_pkg.sv
// Shared router defaults: header/payload widths, stream width derivation and
// the injector FSM state type.
package router_pkg;

    localparam int unsigned NET_WIDTH_DEF  = 4;
    localparam int unsigned DATA_WIDTH_DEF = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } inj_state_e;

    // Router word is {header, payload}; header sits above the payload bits.
    function automatic int unsigned stream_width_f(input int unsigned dw,
                                                   input int unsigned nw);
        return dw + nw;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Single-clock FIFO with extra-bit pointers for full/empty; head reads as
// zero while empty.
module stream_fifo
    import router_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [width-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [width-1:0] dout,
    output logic             empty
);

    localparam int unsigned AW = $clog2(depth);

    logic [width-1:0] mem_q [depth];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + (AW+1)'(1) : rd_q;
        dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/node_inject.sv
// Burst injector: accepts {addr,len} requests, tags each payload word with the
// latched address and buffers it for the router. INJECT_STATS_EN adds stat_words.
module node_inject
    import router_pkg::*;
#(
    parameter int unsigned net_width  = NET_WIDTH_DEF,
    parameter int unsigned data_width = DATA_WIDTH_DEF,
    parameter int unsigned depth      = 4,
    parameter int unsigned len_width  = 4,
    localparam int unsigned stream_width = stream_width_f(data_width, net_width)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    input  logic [net_width-1:0]    req_addr,
    input  logic [len_width-1:0]    req_len,
    output logic                    req_ready,
    input  logic                    dat_valid,
    input  logic [data_width-1:0]   dat,
    output logic                    dat_ready,
    output logic                    out_valid,
    output logic [stream_width-1:0] out_stream,
    input  logic                    out_ready,
    output logic                    busy
`ifdef INJECT_STATS_EN
    ,
    output logic [15:0]             stat_words
`endif
);

    inj_state_e            state_q, state_d;
    logic [net_width-1:0]  addr_q, addr_d;
    logic [len_width-1:0]  count_q, count_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = BURST;
                    addr_d  = req_addr;
                    count_d = req_len;
                end
            end
            BURST: begin
                if (accept) begin
                    if (count_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        count_d = count_q - len_width'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // dat_ready looks only at full, so a same-cycle pop never frees a slot early.
    always_comb begin
        req_ready = (state_q == IDLE);
        dat_ready = (state_q == BURST) && !fifo_full;
        accept    = dat_valid && dat_ready;
        out_valid = !fifo_empty;
        busy      = (state_q == BURST) || !fifo_empty;
    end

    stream_fifo #(
        .width (stream_width),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   ({addr_q, dat}),
        .full  (fifo_full),
        .pop   (out_ready),
        .dout  (out_stream),
        .empty (fifo_empty)
    );

`ifdef INJECT_STATS_EN
    logic [15:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (out_valid && out_ready && (stat_q != '1)) begin
            stat_d = stat_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_words = stat_q;
`endif

endmodule

// File: tb/tb_node_inject.sv
// Directed plus random checks of node_inject against a queue-based burst model.
// Build with INJECT_STATS_EN to also check the saturating handshake counter.
module tb_node_inject;

    localparam int unsigned NW    = 4;
    localparam int unsigned DW    = 128;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 4;
    localparam int unsigned SW    = NW + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [NW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          req_ready;
    logic          dat_valid;
    logic [DW-1:0] dat;
    logic          dat_ready;
    logic          out_valid;
    logic [SW-1:0] out_stream;
    logic          out_ready;
    logic          busy;
`ifdef INJECT_STATS_EN
    logic [15:0]   stat_words;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: burst bookkeeping plus a queue of words owed to the router.
    bit            m_burst;
    logic [NW-1:0] m_addr;
    int            m_left;
    logic [SW-1:0] m_q[$];
    int            m_stat;

    node_inject #(
        .net_width  (NW),
        .data_width (DW),
        .depth      (DEPTH),
        .len_width  (LW)
    ) dut (
`ifdef INJECT_STATS_EN
        .stat_words (stat_words),
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .dat_valid  (dat_valid),
        .dat        (dat),
        .dat_ready  (dat_ready),
        .out_valid  (out_valid),
        .out_stream (out_stream),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_burst = 1'b0;
        m_addr  = '0;
        m_left  = 0;
        m_q.delete();
        m_stat  = 0;
    endtask

    task automatic check_outs(input string tag);
        logic [SW-1:0] head;
        head = (m_q.size() != 0) ? m_q[0] : '0;
        check({tag, ".req_ready"},  SW'(req_ready),  SW'(!m_burst));
        check({tag, ".dat_ready"},  SW'(dat_ready),  SW'(m_burst && (m_q.size() < DEPTH)));
        check({tag, ".out_valid"},  SW'(out_valid),  SW'(m_q.size() != 0));
        check({tag, ".out_stream"}, out_stream,      head);
        check({tag, ".busy"},       SW'(busy),       SW'(m_burst || (m_q.size() != 0)));
`ifdef INJECT_STATS_EN
        check({tag, ".stat_words"}, SW'(stat_words), SW'(m_stat));
`endif
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Entered at a falling edge: check, drive, advance model across the rising edge.
    task automatic cycle(input string tag, input logic rv, input logic [NW-1:0] ra,
                         input logic [LW-1:0] rl, input logic dv, input logic [DW-1:0] d,
                         input logic ordy);
        bit acc_req, acc_dat, do_pop;
        check_outs(tag);
        req_valid = rv;
        req_addr  = ra;
        req_len   = rl;
        dat_valid = dv;
        dat       = d;
        out_ready = ordy;
        acc_req = rv && !m_burst;
        acc_dat = dv && m_burst && (m_q.size() < DEPTH);
        do_pop  = ordy && (m_q.size() != 0);
        @(posedge clk);
        if (do_pop) begin
            void'(m_q.pop_front());
            if (m_stat < 65535) m_stat++;
        end
        if (acc_dat) begin
            m_q.push_back({m_addr, d});
            m_left--;
            if (m_left == 0) m_burst = 1'b0;
        end
        if (acc_req) begin
            m_burst = 1'b1;
            m_addr  = ra;
            m_left  = int'(rl) + 1;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        dat_valid = 1'b0;
        dat       = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outs("reset");
        rst_n = 1'b1;

        // Single word, header 5.
        cycle("single_req", 1'b1, 4'h5, 4'd0, 1'b0, '0, 1'b1);
        cycle("single_dat", 1'b0, '0, '0, 1'b1, DW'(8'hAA), 1'b1);
        check("single_head", out_stream, {4'h5, DW'(8'hAA)});
        cycle("single_out", 1'b0, '0, '0, 1'b0, '0, 1'b1);
        cycle("single_idle", 1'b0, '0, '0, 1'b0, '0, 1'b1);

        // Backpressure: six words into a four-deep buffer, then drain.
        cycle("bp_req", 1'b1, 4'h9, 4'd5, 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) cycle("bp_fill", 1'b0, '0, '0, 1'b1, DW'(100 + i), 1'b0);
        check("bp_stall_ready", SW'(dat_ready), SW'(0));
        for (int i = 0; i < 10; i++) cycle("bp_drain", 1'b0, '0, '0, 1'b1, DW'(100 + i), 1'b1);

        // Concurrent push/pop with two words resident.
        cycle("cc_req", 1'b1, 4'hA, 4'd15, 1'b0, '0, 1'b0);
        cycle("cc_pre0", 1'b0, '0, '0, 1'b1, rnd_data(), 1'b0);
        cycle("cc_pre1", 1'b0, '0, '0, 1'b1, rnd_data(), 1'b0);
        for (int i = 0; i < 14; i++) begin
            cycle("cc_run", 1'b0, '0, '0, 1'b1, rnd_data(), 1'b1);
            check("cc_occupancy", SW'(m_q.size()), SW'(2));
        end
        for (int i = 0; i < 4; i++) cycle("cc_tail", 1'b0, '0, '0, 1'b0, '0, 1'b1);

        // Reset mid-burst after two of four words.
        cycle("rst_req", 1'b1, 4'h7, 4'd3, 1'b0, '0, 1'b0);
        cycle("rst_w0", 1'b0, '0, '0, 1'b1, rnd_data(), 1'b0);
        cycle("rst_w1", 1'b0, '0, '0, 1'b1, rnd_data(), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("rst_clean_req", 1'b1, 4'h2, 4'd0, 1'b0, '0, 1'b1);
        cycle("rst_clean_dat", 1'b0, '0, '0, 1'b1, rnd_data(), 1'b1);
        cycle("rst_clean_out", 1'b0, '0, '0, 1'b0, '0, 1'b1);

        // Back-to-back bursts: headers 3,3,C,C.
        cycle("b2b_req0", 1'b1, 4'h3, 4'd1, 1'b0, '0, 1'b1);
        cycle("b2b_w0", 1'b1, 4'hC, 4'd1, 1'b1, rnd_data(), 1'b1);
        cycle("b2b_w1", 1'b1, 4'hC, 4'd1, 1'b1, rnd_data(), 1'b1);
        cycle("b2b_req1", 1'b1, 4'hC, 4'd1, 1'b0, '0, 1'b1);
        cycle("b2b_w2", 1'b0, '0, '0, 1'b1, rnd_data(), 1'b1);
        cycle("b2b_w3", 1'b0, '0, '0, 1'b1, rnd_data(), 1'b1);
        for (int i = 0; i < 3; i++) cycle("b2b_out", 1'b0, '0, '0, 1'b0, '0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 3) == 0), NW'($urandom()), LW'($urandom_range(0, 6)),
                  ($urandom_range(0, 3) != 0), rnd_data(), ($urandom_range(0, 1) == 1));
        end
        for (int i = 0; i < 12; i++) cycle("rand_flush", 1'b0, '0, '0, 1'b1, rnd_data(), 1'b1);

`ifdef INJECT_STATS_EN
        // Drive the handshake counter past saturation, then clear it by reset.
        for (int i = 0; i < 80000 && m_stat < 65535 + 10; i++) begin
            cycle("stat_run", !m_burst, 4'h1, 4'd15, 1'b1, DW'(i), 1'b1);
            if (m_stat == 65535) m_stat = 65535 + 10;
        end
        m_stat = 65535;
        for (int i = 0; i < 20; i++) cycle("stat_sat", !m_burst, 4'h1, 4'd15, 1'b1, DW'(i), 1'b1);
        check("stat_saturated", SW'(stat_words), SW'(16'hFFFF));
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("stat_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("stat_after", 1'b0, '0, '0, 1'b0, '0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/node_inject.md
NODE_INJECT -- requirements
Module: node_inject

Interface
REQ-001 Parameter net_width, default 4, width of the network address header field.
REQ-002 Parameter data_width, default 128, width of the payload word.
REQ-003 Parameter depth, default 4, FIFO entries; power of two, at least 2.
REQ-004 Parameter len_width, default 4, width of the burst length field.
REQ-005 Derived constant stream_width = data_width + net_width; header occupies bits [stream_width-1 : data_width].
REQ-006 One clock, clk; asynchronous active-low reset, rst_n.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 req_valid  in  1  burst request strobe.
REQ-010 req_addr  in  net_width  destination network address of the burst.
REQ-011 req_len  in  len_width  burst length minus one.
REQ-012 req_ready  out  1  request accepted when high with req_valid.
REQ-013 dat_valid  in  1  payload word valid.
REQ-014 dat  in  data_width  payload word.
REQ-015 dat_ready  out  1  payload word accepted when high with dat_valid.
REQ-016 out_valid  out  1  out_stream holds a valid router word.
REQ-017 out_stream  out  stream_width  {addr, data} word to the router local input port.
REQ-018 out_ready  in  1  router consumes the word when high with out_valid.
REQ-019 busy  out  1  high in BURST or when the FIFO is non-empty.

Function
REQ-020 FSM states: IDLE, BURST; req_ready = (state==IDLE).
REQ-021 IDLE, req_valid: latch req_addr and count=req_len, go to BURST next cycle.
REQ-022 dat_ready = (state==BURST) and FIFO not full; no full-FIFO pass-through, even if a pop occurs in the same cycle.
REQ-023 Each accepted word pushes {latched addr, dat}; count decrements; accept at count==0 returns FSM to IDLE.
REQ-024 A burst carries exactly req_len+1 words; req_len=0 means one word.
REQ-025 out_valid = FIFO not empty; out_stream = FIFO head, stable while out_valid and not out_ready.
REQ-026 Latency: a word accepted at edge N appears on out_valid/out_stream after edge N (one cycle).
REQ-027 Simultaneous push and pop in a non-empty, non-full FIFO keeps occupancy unchanged; order strictly FIFO.
REQ-028 Read/write pointers wrap modulo depth; full/empty via one extra pointer bit.
REQ-029 out_stream drives zero when the FIFO is empty.

Reset
REQ-030 rst_n low: FSM=IDLE, FIFO empty, count=0, latched addr=0 immediately, independent of clk.
REQ-031 Outputs under reset: req_ready=1, dat_ready=0, out_valid=0, out_stream=0, busy=0.
REQ-032 Reset mid-burst discards the partial burst and all buffered words; no recovery.

Configuration
REQ-033 Macro INJECT_STATS_EN defined: adds output stat_words (16 bits), counting out_valid&&out_ready handshakes, saturating at 0xFFFF, reset to 0.
REQ-034 INJECT_STATS_EN undefined: no stat_words port, no counter logic; all other behaviour identical.

Structure
REQ-035 Shared package router_pkg holds the net_width/data_width defaults, stream_width derivation and the IDLE/BURST state typedef.
REQ-036 Sub-module stream_fifo (synchronous, parameterised width/depth, push/pop/full/empty) holds the buffer; node_inject holds the FSM and header insertion.

Verification
REQ-037 Single word: req addr=0x5 len=0, dat=0xAA, out_ready=1 -> out_stream=0x5_..._AA one cycle later, FSM back to IDLE.
REQ-038 Backpressure: burst len=5 (6 words), out_ready=0 -> dat_ready drops after 4 words; raising out_ready drains all 6 words in order.
REQ-039 Concurrent push/pop: depth=4 FIFO holding 2 words, continuous dat and out_ready -> occupancy holds at 2, no loss or duplicate over 16 words.
REQ-040 Reset mid-burst: assert rst_n=0 after 2 of 4 words -> out_valid=0, busy=0, req_ready=1 immediately; next burst starts clean.
REQ-041 Back-to-back bursts: addr 0x3 len=1 then addr 0xC len=1 -> four words with headers 3,3,C,C; req_ready low throughout each burst.
REQ-042 INJECT_STATS_EN defined: 70000 handshakes -> stat_words=0xFFFF; reset -> 0.
